// File: rtl/awsf1_pkg.sv
// Shared types and constants for the SDA AXI4-Lite to MMIO bridge.
// Provides AXI response codes, the bridge FSM state enum and the timeout fill word.
package awsf1_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] TIMEOUT_FILL = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_RD_RESP
  } state_e;

endpackage

// File: rtl/awsf1_axil_hold.sv
// Single-entry holding register with a full flag for one AXI-Lite channel.
// Ports: clk_i, rst_ni, set_i (load data_i), clr_i (empty), full_o, data_o.
module awsf1_axil_hold #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         set_i,
  input  logic         clr_i,
  input  logic [W-1:0] data_i,
  output logic         full_o,
  output logic [W-1:0] data_o
);

  logic         full_q;
  logic [W-1:0] data_q;

  // Clear beats set: a beat consumed in the cycle it arrives never fills.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      if (set_i) data_q <= data_i;
      if (clr_i) full_q <= 1'b0;
      else if (set_i) full_q <= 1'b1;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/awsf1_sda_axil_bridge.sv
// AXI4-Lite slave on the shell SDA bus that issues one MMIO request at a time.
// Ports: clk/reset, sda_cl_*/cl_sda_* AXI-Lite, req_* MMIO request, rd_rsp_* read return.
module awsf1_sda_axil_bridge
  import awsf1_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT     = 32'h0010_0000,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_main_a0,
  input  logic        rst_main_n,
  input  logic        sda_cl_awvalid,
  output logic        cl_sda_awready,
  input  logic [31:0] sda_cl_awaddr,
  input  logic        sda_cl_wvalid,
  output logic        cl_sda_wready,
  input  logic [31:0] sda_cl_wdata,
  input  logic [3:0]  sda_cl_wstrb,
  output logic        cl_sda_bvalid,
  output logic [1:0]  cl_sda_bresp,
  input  logic        sda_cl_bready,
  input  logic        sda_cl_arvalid,
  output logic        cl_sda_arready,
  input  logic [31:0] sda_cl_araddr,
  output logic        cl_sda_rvalid,
  output logic [31:0] cl_sda_rdata,
  output logic [1:0]  cl_sda_rresp,
  input  logic        sda_cl_rready,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_write,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_wstrb,
  input  logic        rd_rsp_valid,
  input  logic [31:0] rd_rsp_data
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_e state_q, state_d;

  logic          live_q;
  logic          last_rd_q;
  logic          seen_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    bresp_q;
  logic [1:0]    rresp_q;
  logic [31:0]   rdata_q;

  logic        aw_full, w_full, ar_full;
  logic [31:0] aw_addr, ar_addr, w_data;
  logic [3:0]  w_strb;
  logic        aw_clr, ar_clr;

  logic idle;
  logic aw_fire, w_fire, ar_fire;
  logic wr_rdy, rd_rdy;
  logic grant_wr, grant_rd;
  logic wr_dec, rd_dec;
  logic [31:0] wr_addr, rd_addr;

  assign idle = (state_q == ST_IDLE);

  // live_q keeps all readies low through reset and its first cycle out.
  assign cl_sda_awready = live_q & idle & ~aw_full;
  assign cl_sda_wready  = live_q & idle & ~w_full;
  assign cl_sda_arready = live_q & idle & ~aw_full & ~w_full & ~ar_full;

  assign aw_fire = sda_cl_awvalid & cl_sda_awready;
  assign w_fire  = sda_cl_wvalid  & cl_sda_wready;
  assign ar_fire = sda_cl_arvalid & cl_sda_arready;

  awsf1_axil_hold #(.W(32)) u_aw (
    .clk_i  (clk_main_a0),
    .rst_ni (rst_main_n),
    .set_i  (aw_fire),
    .clr_i  (aw_clr),
    .data_i (sda_cl_awaddr),
    .full_o (aw_full),
    .data_o (aw_addr)
  );

  awsf1_axil_hold #(.W(36)) u_w (
    .clk_i  (clk_main_a0),
    .rst_ni (rst_main_n),
    .set_i  (w_fire),
    .clr_i  (aw_clr),
    .data_i ({sda_cl_wstrb, sda_cl_wdata}),
    .full_o (w_full),
    .data_o ({w_strb, w_data})
  );

  awsf1_axil_hold #(.W(32)) u_ar (
    .clk_i  (clk_main_a0),
    .rst_ni (rst_main_n),
    .set_i  (ar_fire),
    .clr_i  (ar_clr),
    .data_i (sda_cl_araddr),
    .full_o (ar_full),
    .data_o (ar_addr)
  );

  // Beats landing this cycle count, so IDLE can dispatch without a bubble.
  assign wr_rdy  = (aw_full | aw_fire) & (w_full | w_fire);
  assign rd_rdy  = ar_full | ar_fire;
  assign wr_addr = aw_full ? aw_addr : sda_cl_awaddr;
  assign rd_addr = ar_full ? ar_addr : sda_cl_araddr;
  assign wr_dec  = (wr_addr >= ADDR_LIMIT);
  assign rd_dec  = (rd_addr >= ADDR_LIMIT);

  // On a tie the side not served last wins; before any grant, write wins.
  assign grant_wr = idle & wr_rdy & (~rd_rdy | ~seen_q | last_rd_q);
  assign grant_rd = idle & rd_rdy & ~grant_wr;

  always_comb begin
    state_d = state_q;
    aw_clr  = 1'b0;
    ar_clr  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_wr) begin
          state_d = wr_dec ? ST_WR_RESP : ST_WR_REQ;
          aw_clr  = wr_dec;
        end else if (grant_rd) begin
          state_d = rd_dec ? ST_RD_RESP : ST_RD_REQ;
          ar_clr  = rd_dec;
        end
      end
      ST_WR_REQ: begin
        if (req_ready) begin
          state_d = ST_WR_RESP;
          aw_clr  = 1'b1;
        end
      end
      ST_WR_RESP: if (sda_cl_bready) state_d = ST_IDLE;
      ST_RD_REQ: begin
        if (req_ready) begin
          state_d = ST_RD_WAIT;
          ar_clr  = 1'b1;
        end
      end
      ST_RD_WAIT: begin
        if (rd_rsp_valid || cnt_q == CNT_LAST) state_d = ST_RD_RESP;
      end
      ST_RD_RESP: if (sda_cl_rready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      state_q   <= ST_IDLE;
      live_q    <= 1'b0;
      last_rd_q <= 1'b0;
      seen_q    <= 1'b0;
      cnt_q     <= '0;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      if (grant_wr | grant_rd) begin
        seen_q    <= 1'b1;
        last_rd_q <= grant_rd;
      end
      if (grant_wr) bresp_q <= wr_dec ? RESP_DECERR : RESP_OKAY;
      if (grant_rd && rd_dec) begin
        rresp_q <= RESP_DECERR;
        rdata_q <= '0;
      end
      if (state_q == ST_RD_REQ && req_ready) cnt_q <= '0;
      if (state_q == ST_RD_WAIT) begin
        if (rd_rsp_valid) begin
          rdata_q <= rd_rsp_data;
          rresp_q <= RESP_OKAY;
        end else if (cnt_q == CNT_LAST) begin
          rdata_q <= TIMEOUT_FILL;
          rresp_q <= RESP_SLVERR;
        end
        if (cnt_q != {CW{1'b1}}) cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign cl_sda_bvalid = (state_q == ST_WR_RESP);
  assign cl_sda_bresp  = bresp_q;
  assign cl_sda_rvalid = (state_q == ST_RD_RESP);
  assign cl_sda_rresp  = rresp_q;
  assign cl_sda_rdata  = rdata_q;

  assign req_valid = (state_q == ST_WR_REQ) | (state_q == ST_RD_REQ);
  assign req_write = (state_q == ST_WR_REQ);
  assign req_addr  = (state_q == ST_WR_REQ) ? aw_addr :
                     (state_q == ST_RD_REQ) ? ar_addr : 32'h0;
  assign req_wdata = (state_q == ST_WR_REQ) ? w_data : 32'h0;
  assign req_wstrb = (state_q == ST_WR_REQ) ? w_strb : 4'h0;

endmodule

// File: tb/tb_awsf1_sda_axil_bridge.sv
// Self-checking bench for awsf1_sda_axil_bridge.
// Randomized AXI-Lite traffic checked against a transaction-level model.
module tb_awsf1_sda_axil_bridge;

  localparam logic [31:0] LIMIT = 32'h0010_0000;
  localparam int TMO = 1024;

  logic clk_main_a0, rst_main_n;
  logic sda_cl_awvalid, cl_sda_awready;
  logic [31:0] sda_cl_awaddr;
  logic sda_cl_wvalid, cl_sda_wready;
  logic [31:0] sda_cl_wdata;
  logic [3:0] sda_cl_wstrb;
  logic cl_sda_bvalid, sda_cl_bready;
  logic [1:0] cl_sda_bresp;
  logic sda_cl_arvalid, cl_sda_arready;
  logic [31:0] sda_cl_araddr;
  logic cl_sda_rvalid, sda_cl_rready;
  logic [31:0] cl_sda_rdata;
  logic [1:0] cl_sda_rresp;
  logic req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0] req_wstrb;
  logic rd_rsp_valid;
  logic [31:0] rd_rsp_data;

  awsf1_sda_axil_bridge dut (
    .clk_main_a0(clk_main_a0), .rst_main_n(rst_main_n),
    .sda_cl_awvalid(sda_cl_awvalid), .cl_sda_awready(cl_sda_awready),
    .sda_cl_awaddr(sda_cl_awaddr),
    .sda_cl_wvalid(sda_cl_wvalid), .cl_sda_wready(cl_sda_wready),
    .sda_cl_wdata(sda_cl_wdata), .sda_cl_wstrb(sda_cl_wstrb),
    .cl_sda_bvalid(cl_sda_bvalid), .cl_sda_bresp(cl_sda_bresp),
    .sda_cl_bready(sda_cl_bready),
    .sda_cl_arvalid(sda_cl_arvalid), .cl_sda_arready(cl_sda_arready),
    .sda_cl_araddr(sda_cl_araddr),
    .cl_sda_rvalid(cl_sda_rvalid), .cl_sda_rdata(cl_sda_rdata),
    .cl_sda_rresp(cl_sda_rresp), .sda_cl_rready(sda_cl_rready),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data)
  );

  initial clk_main_a0 = 1'b0;
  always #5 clk_main_a0 = ~clk_main_a0;

  int n_checks = 0;
  int n_pass = 0;
  int unsigned cyc = 0;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int unsigned at;
  } req_t;
  req_t reqs[$];

  always @(posedge clk_main_a0) begin
    cyc <= cyc + 1;
    if (rst_main_n && req_valid && req_ready)
      reqs.push_back('{wr: req_write, addr: req_addr, data: req_wdata,
                       strb: req_wstrb, at: cyc});
  end

  typedef struct {
    int unsigned base;
    int nb, nr, rv_cycles, unstable;
    logic [1:0] bresp, rresp;
    logic [31:0] rdata;
    int b_cyc, r_cyc, ar_cyc;
  } res_t;

  function automatic logic [110:0] all_outs();
    return {cl_sda_awready, cl_sda_wready, cl_sda_bvalid, cl_sda_bresp,
            cl_sda_arready, cl_sda_rvalid, cl_sda_rdata, cl_sda_rresp,
            req_valid, req_write, req_addr, req_wdata, req_wstrb};
  endfunction

  function automatic logic [68:0] req_at(int idx);
    if (idx >= reqs.size()) return 'x;
    return {reqs[idx].wr, reqs[idx].addr, reqs[idx].data, reqs[idx].strb};
  endfunction

  function automatic int req_cyc(int idx, int unsigned base);
    if (idx >= reqs.size()) return -1;
    return int'(reqs[idx].at - base);
  endfunction

  function automatic logic [31:0] addr_in();
    return 32'($urandom_range(0, 32'h3FFFF)) << 2;
  endfunction

  function automatic logic [31:0] addr_out();
    case ($urandom_range(0, 2))
      0: return LIMIT;
      1: return 32'hFFFF_FFFC;
      default: return ($urandom | LIMIT) & 32'hFFFF_FFFC;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk_main_a0);
    #1;
  endtask

  // Drives AW/W/AR from the given start cycles (-1 = unused) and logs
  // responses; rd_rsp_valid, req_ready and rready follow the windows.
  task automatic drive_mix(
    input int aws, ws, ars,
    input logic [31:0] awa, wd, input logic [3:0] wst,
    input logic [31:0] ara, rspd,
    input int rs0, rs1, rq0, rq1, rr0, rr1, maxc,
    output res_t r);
    bit awd, wdn, ard, awf, wf, arf;
    bit ph, prh;
    logic [68:0] pq;
    logic [33:0] pr;
    r = '{default: 0};
    r.b_cyc = -1; r.r_cyc = -1; r.ar_cyc = -1;
    awd = (aws < 0); wdn = (ws < 0); ard = (ars < 0);
    ph = 0; prh = 0; pq = '0; pr = '0;
    r.base = cyc;
    for (int c = 0; c < maxc; c++) begin
      sda_cl_awvalid = !awd && c >= aws;
      sda_cl_awaddr  = awa;
      sda_cl_wvalid  = !wdn && c >= ws;
      sda_cl_wdata   = wd;
      sda_cl_wstrb   = wst;
      sda_cl_arvalid = !ard && c >= ars;
      sda_cl_araddr  = ara;
      rd_rsp_valid   = (c >= rs0 && c < rs1);
      rd_rsp_data    = rspd;
      req_ready      = !(c >= rq0 && c < rq1);
      sda_cl_bready  = 1'b1;
      sda_cl_rready  = !(c >= rr0 && c < rr1);
      if (ph && {req_write, req_addr, req_wdata, req_wstrb} !== pq)
        r.unstable++;
      if (prh && {cl_sda_rresp, cl_sda_rdata} !== pr) r.unstable++;
      if (cl_sda_bvalid) begin
        r.nb++; r.bresp = cl_sda_bresp; r.b_cyc = c;
      end
      if (cl_sda_rvalid) r.rv_cycles++;
      if (cl_sda_rvalid && sda_cl_rready) begin
        r.nr++; r.rresp = cl_sda_rresp; r.rdata = cl_sda_rdata; r.r_cyc = c;
      end
      ph  = req_valid && !req_ready;
      pq  = {req_write, req_addr, req_wdata, req_wstrb};
      prh = cl_sda_rvalid && !sda_cl_rready;
      pr  = {cl_sda_rresp, cl_sda_rdata};
      awf = sda_cl_awvalid && cl_sda_awready;
      wf  = sda_cl_wvalid && cl_sda_wready;
      arf = sda_cl_arvalid && cl_sda_arready;
      if (arf) r.ar_cyc = c;
      tick();
      if (awf) awd = 1;
      if (wf) wdn = 1;
      if (arf) ard = 1;
    end
    sda_cl_awvalid = 0; sda_cl_wvalid = 0; sda_cl_arvalid = 0;
    rd_rsp_valid = 0; req_ready = 1; sda_cl_rready = 1;
  endtask

  task automatic test_reset();
    rst_main_n = 0;
    sda_cl_awvalid = 0; sda_cl_awaddr = 0; sda_cl_wvalid = 0;
    sda_cl_wdata = 0; sda_cl_wstrb = 0; sda_cl_bready = 0;
    sda_cl_arvalid = 0; sda_cl_araddr = 0; sda_cl_rready = 0;
    req_ready = 0; rd_rsp_valid = 0; rd_rsp_data = 0;
    repeat (3) tick();
    n_checks++;
    if (all_outs() !== '0)
      $display("FAIL reset_outs: got %h want 0", all_outs());
    else n_pass++;
    rst_main_n = 1;
    tick();
    n_checks++;
    if ({cl_sda_awready, cl_sda_wready, cl_sda_arready} !== 3'b111)
      $display("FAIL reset_ready: got %b want 111",
               {cl_sda_awready, cl_sda_wready, cl_sda_arready});
    else n_pass++;
  endtask

  task automatic test_tie();
    res_t r;
    int i0;
    logic [31:0] wa, wd, ra, rd;
    logic [68:0] g;
    wa = addr_in(); wd = $urandom; ra = addr_in(); rd = $urandom;
    i0 = reqs.size();
    drive_mix(0, 0, 0, wa, wd, 4'hF, ra, rd, 0, 99, -1, -1, -1, -1, 12, r);
    g = req_at(i0);
    n_checks++;
    if (g !== {1'b1, wa, wd, 4'hF} || req_cyc(i0, r.base) != 1)
      $display("FAIL tie1_write_first: got %h @%0d want %h @1", g,
               req_cyc(i0, r.base), {1'b1, wa, wd, 4'hF});
    else n_pass++;
    g = req_at(i0 + 1);
    n_checks++;
    if ({g[68:36], g[3:0]} !== {1'b0, ra, 4'h0} || r.r_cyc != 6)
      $display("FAIL tie1_read_second: got %h rcyc %0d want %h rcyc 6",
               {g[68:36], g[3:0]}, r.r_cyc, {1'b0, ra, 4'h0});
    else n_pass++;
    drive_mix(0, 0, -1, addr_in(), $urandom, 4'h3, 0, 0, 0, 0,
              -1, -1, -1, -1, 6, r);
    i0 = reqs.size();
    drive_mix(0, 0, 0, wa, wd, 4'h5, ra, rd, 0, 99, -1, -1, -1, -1, 12, r);
    n_checks++;
    if (req_at(i0) === 'x || reqs[i0].wr !== 1'b0 ||
        r.r_cyc != 3 || r.b_cyc != 6 || r.rdata !== rd)
      $display("FAIL tie2_read_first: rcyc %0d bcyc %0d rdata %h want 3 6 %h",
               r.r_cyc, r.b_cyc, r.rdata, rd);
    else n_pass++;
  endtask

  task automatic test_write();
    res_t r;
    int i0, ereq, eb;
    bit dec;
    logic [31:0] a, d;
    logic [3:0] s;
    logic [1:0] er;
    for (int i = 0; i < 10; i++) begin
      dec = (i > 0) && ($urandom_range(0, 2) == 0);
      a = (i == 0) ? 32'h10 : dec ? addr_out() : addr_in();
      if (i == 1) a = LIMIT - 4;
      d = (i == 0) ? 32'hA5A5_0001 : $urandom;
      s = (i == 0) ? 4'hF : 4'($urandom);
      er = (a >= LIMIT) ? 2'b11 : 2'b00;
      ereq = (a >= LIMIT) ? 0 : 1;
      eb = (a >= LIMIT) ? 1 : 2;
      i0 = reqs.size();
      drive_mix(0, 0, -1, a, d, s, 0, 0, 0, 0, -1, -1, -1, -1, 6, r);
      n_checks++;
      if (r.nb != 1 || r.bresp !== er || r.b_cyc != eb)
        $display("FAIL wr_resp[%0d]: nb %0d bresp %b cyc %0d want 1 %b %0d",
                 i, r.nb, r.bresp, r.b_cyc, er, eb);
      else n_pass++;
      n_checks++;
      if (reqs.size() - i0 != ereq)
        $display("FAIL wr_reqcount[%0d]: got %0d want %0d", i,
                 reqs.size() - i0, ereq);
      else n_pass++;
      if (ereq == 1) begin
        n_checks++;
        if (req_at(i0) !== {1'b1, a, d, s} || req_cyc(i0, r.base) != 1)
          $display("FAIL wr_req[%0d]: got %h @%0d want %h @1", i,
                   req_at(i0), req_cyc(i0, r.base), {1'b1, a, d, s});
        else n_pass++;
      end
    end
  endtask

  task automatic test_read();
    res_t r;
    int i0, k, er_cyc;
    logic [31:0] a, d, ed;
    logic [1:0] er;
    logic [68:0] g;
    for (int i = 0; i < 10; i++) begin
      a = (i == 0) ? 32'h20 : ($urandom_range(0, 2) == 0) ? addr_out() : addr_in();
      d = (i == 0) ? 32'h1234_5678 : $urandom;
      k = 2 + ((i == 0) ? 5 : $urandom_range(0, 6));
      er = (a >= LIMIT) ? 2'b11 : 2'b00;
      ed = (a >= LIMIT) ? 32'h0 : d;
      er_cyc = (a >= LIMIT) ? 1 : k + 1;
      i0 = reqs.size();
      drive_mix(-1, -1, 0, 0, 0, 0, a, d, k, k + 1, -1, -1, -1, -1, 12, r);
      n_checks++;
      if (r.nr != 1 || r.rresp !== er || r.rdata !== ed || r.r_cyc != er_cyc)
        $display("FAIL rd_resp[%0d]: nr %0d rresp %b rdata %h cyc %0d want 1 %b %h %0d",
                 i, r.nr, r.rresp, r.rdata, r.r_cyc, er, ed, er_cyc);
      else n_pass++;
      n_checks++;
      if (reqs.size() - i0 != ((a >= LIMIT) ? 0 : 1))
        $display("FAIL rd_reqcount[%0d]: got %0d", i, reqs.size() - i0);
      else n_pass++;
      if (a < LIMIT) begin
        g = req_at(i0);
        n_checks++;
        if ({g[68:36], g[3:0]} !== {1'b0, a, 4'h0} || req_cyc(i0, r.base) != 1)
          $display("FAIL rd_req[%0d]: got %h @%0d want %h @1", i,
                   {g[68:36], g[3:0]}, req_cyc(i0, r.base), {1'b0, a, 4'h0});
        else n_pass++;
      end
    end
  endtask

  task automatic test_w_before_aw();
    res_t r;
    int i0;
    logic [31:0] wa, wd, ra, rd;
    wa = addr_in(); wd = $urandom; ra = addr_in(); rd = $urandom;
    i0 = reqs.size();
    drive_mix(3, 0, 1, wa, wd, 4'hC, ra, rd, 0, 99, -1, -1, -1, -1, 14, r);
    n_checks++;
    if (req_at(i0) !== {1'b1, wa, wd, 4'hC} || req_cyc(i0, r.base) != 4)
      $display("FAIL wfirst_write: got %h @%0d want %h @4", req_at(i0),
               req_cyc(i0, r.base), {1'b1, wa, wd, 4'hC});
    else n_pass++;
    n_checks++;
    if (r.b_cyc != 5 || r.ar_cyc != 6)
      $display("FAIL wfirst_ar_blocked: bcyc %0d arcyc %0d want 5 6",
               r.b_cyc, r.ar_cyc);
    else n_pass++;
    n_checks++;
    if (req_cyc(i0 + 1, r.base) != 7 || r.r_cyc != 9 || r.rdata !== rd)
      $display("FAIL wfirst_read: req@%0d rcyc %0d rdata %h want 7 9 %h",
               req_cyc(i0 + 1, r.base), r.r_cyc, r.rdata, rd);
    else n_pass++;
  endtask

  task automatic test_timeout();
    res_t r;
    drive_mix(-1, -1, 0, 0, 0, 0, 32'h20, $urandom, 1100, 1104,
              -1, -1, -1, -1, 1120, r);
    n_checks++;
    if (r.r_cyc != 2 + TMO || r.rresp !== 2'b10 || r.rdata !== 32'hDEAD_BEEF)
      $display("FAIL timeout: cyc %0d rresp %b rdata %h want %0d 10 deadbeef",
               r.r_cyc, r.rresp, r.rdata, 2 + TMO);
    else n_pass++;
    n_checks++;
    if (r.nr != 1 || r.rv_cycles != 1)
      $display("FAIL late_rsp_dropped: nr %0d rvalid cycles %0d want 1 1",
               r.nr, r.rv_cycles);
    else n_pass++;
  endtask

  task automatic test_decerr();
    res_t r;
    int i0;
    i0 = reqs.size();
    drive_mix(0, 0, -1, LIMIT, $urandom, 4'hF, 0, 0, 0, 0,
              -1, -1, -1, -1, 5, r);
    n_checks++;
    if (r.bresp !== 2'b11 || r.b_cyc != 1 || r.nb != 1)
      $display("FAIL decerr_write: bresp %b cyc %0d nb %0d want 11 1 1",
               r.bresp, r.b_cyc, r.nb);
    else n_pass++;
    drive_mix(-1, -1, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'hCAFE_F00D, 0, 99,
              -1, -1, -1, -1, 5, r);
    n_checks++;
    if (r.rresp !== 2'b11 || r.rdata !== 32'h0 || r.r_cyc != 1)
      $display("FAIL decerr_read: rresp %b rdata %h cyc %0d want 11 0 1",
               r.rresp, r.rdata, r.r_cyc);
    else n_pass++;
    n_checks++;
    if (reqs.size() != i0)
      $display("FAIL decerr_noreq: got %0d reqs want 0", reqs.size() - i0);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    res_t r;
    int i0;
    logic [31:0] a, d, rd;
    a = addr_in(); d = $urandom; rd = $urandom;
    i0 = reqs.size();
    drive_mix(0, 0, -1, a, d, 4'h9, 0, 0, 0, 0, 0, 11, -1, -1, 16, r);
    n_checks++;
    if (r.unstable != 0 || reqs.size() - i0 != 1 ||
        req_cyc(i0, r.base) != 11 || req_at(i0) !== {1'b1, a, d, 4'h9})
      $display("FAIL bp_req: unstable %0d n %0d @%0d want 0 1 @11",
               r.unstable, reqs.size() - i0, req_cyc(i0, r.base));
    else n_pass++;
    n_checks++;
    if (r.nb != 1 || r.b_cyc != 12)
      $display("FAIL bp_bresp: nb %0d cyc %0d want 1 12", r.nb, r.b_cyc);
    else n_pass++;
    a = addr_in();
    drive_mix(-1, -1, 0, 0, 0, 0, a, rd, 0, 99, -1, -1, 3, 7, 12, r);
    n_checks++;
    if (r.unstable != 0 || r.nr != 1 || r.r_cyc != 7 ||
        r.rv_cycles != 5 || r.rdata !== rd)
      $display("FAIL bp_rresp: unstable %0d nr %0d cyc %0d rv %0d rdata %h want 0 1 7 5 %h",
               r.unstable, r.nr, r.r_cyc, r.rv_cycles, r.rdata, rd);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    res_t r;
    logic [31:0] rd;
    drive_mix(-1, -1, 0, 0, 0, 0, addr_in(), 0, 99, 99,
              -1, -1, -1, -1, 6, r);
    n_checks++;
    if (r.nr != 0)
      $display("FAIL rstmid_pending: nr %0d want 0", r.nr);
    else n_pass++;
    rst_main_n = 0;
    #1;
    n_checks++;
    if (all_outs() !== '0)
      $display("FAIL rstmid_outs: got %h want 0", all_outs());
    else n_pass++;
    tick(); tick();
    rst_main_n = 1;
    tick(); tick();
    rd = $urandom;
    drive_mix(-1, -1, 0, 0, 0, 0, addr_in(), rd, 0, 99,
              -1, -1, -1, -1, 8, r);
    n_checks++;
    if (r.nr != 1 || r.rv_cycles != 1 || r.r_cyc != 3 ||
        r.rresp !== 2'b00 || r.rdata !== rd)
      $display("FAIL rstmid_next: nr %0d rv %0d cyc %0d rresp %b rdata %h want 1 1 3 00 %h",
               r.nr, r.rv_cycles, r.r_cyc, r.rresp, r.rdata, rd);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_tie();
    test_write();
    test_read();
    test_w_before_aw();
    test_timeout();
    test_decerr();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
